// File: rtl/hc595_chain_driver.sv
// +--------------------------------------------------------------------------+
// | hc595_chain_driver                                                       |
// | Shifts {sel,seg} into two cascaded 74HC595s on change, then latches it.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module hc595_chain_driver #(
  parameter int DIV = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] seg,
  input  logic [7:0] sel,
  output logic       ds,
  output logic       shcp,
  output logic       stcp,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'd15;

  state_t      state, state_nx;
  logic [15:0] shreg, shreg_nx;
  logic [15:0] last_word, last_word_nx;
  logic        first, first_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [3:0]  bitcnt, bitcnt_nx;
  logic        ds_nx, shcp_nx, stcp_nx, busy_nx;
  logic [15:0] word;
  logic        cnt_done;

  assign word     = {sel, seg};
  assign cnt_done = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      shreg     <= 16'd0;
      last_word <= 16'd0;
      first     <= 1'b1;
      cnt       <= 8'd0;
      bitcnt    <= 4'd0;
      ds        <= 1'b0;
      shcp      <= 1'b0;
      stcp      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      shreg     <= shreg_nx;
      last_word <= last_word_nx;
      first     <= first_nx;
      cnt       <= cnt_nx;
      bitcnt    <= bitcnt_nx;
      ds        <= ds_nx;
      shcp      <= shcp_nx;
      stcp      <= stcp_nx;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    shreg_nx     = shreg;
    last_word_nx = last_word;
    first_nx     = first;
    cnt_nx       = cnt;
    bitcnt_nx    = bitcnt;
    ds_nx        = ds;
    shcp_nx      = shcp;
    stcp_nx      = stcp;
    busy_nx      = busy;

    case (state)
      IDLE: begin
        ds_nx   = 1'b0;
        shcp_nx = 1'b0;
        stcp_nx = 1'b0;
        busy_nx = 1'b0;
        // Inputs are sampled only here, so glitches between frames are harmless.
        if (first || (word != last_word)) begin
          shreg_nx     = word;
          last_word_nx = word;
          first_nx     = 1'b0;
          busy_nx      = 1'b1;
          ds_nx        = word[15];
          cnt_nx       = 8'd0;
          bitcnt_nx    = 4'd0;
          state_nx     = SHIFT;
        end
      end

      SHIFT: begin
        if (!cnt_done) begin
          cnt_nx = cnt + 8'd1;
        end else begin
          cnt_nx = 8'd0;
          if (!shcp) begin
            shcp_nx = 1'b1;
          end else begin
            // ds moves on the falling edge, giving a full low phase of setup.
            shcp_nx = 1'b0;
            if (bitcnt == BIT_LAST) begin
              ds_nx    = 1'b0;
              stcp_nx  = 1'b1;
              state_nx = LATCH;
            end else begin
              shreg_nx  = shreg << 1;
              ds_nx     = shreg[14];
              bitcnt_nx = bitcnt + 4'd1;
            end
          end
        end
      end

      LATCH: begin
        if (!cnt_done) begin
          cnt_nx = cnt + 8'd1;
        end else begin
          cnt_nx   = 8'd0;
          stcp_nx  = 1'b0;
          busy_nx  = 1'b0;
          state_nx = IDLE;
        end
      end

      default: begin
        state_nx = IDLE;
        ds_nx    = 1'b0;
        shcp_nx  = 1'b0;
        stcp_nx  = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_hc595_chain_driver.sv
// Bench for hc595_chain_driver: DIV=2 and DIV=1 instances share stimulus;
// a frame-level model predicts latched words, a 595 chain model observes pins.
`default_nettype none

module tb_hc595_chain_driver;

  localparam int DIV_A = 2;
  localparam int DIV_B = 1;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic [7:0] seg = 8'h00;
  logic [7:0] sel = 8'h00;
  logic [1:0] ds, shcp, stcp, busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];

  hc595_chain_driver #(.DIV(DIV_A)) dut_a (
    .clk(clk), .rstn(rstn), .seg(seg), .sel(sel),
    .ds(ds[0]), .shcp(shcp[0]), .stcp(stcp[0]), .busy(busy[0])
  );

  hc595_chain_driver #(.DIV(DIV_B)) dut_b (
    .clk(clk), .rstn(rstn), .seg(seg), .sel(sel),
    .ds(ds[1]), .shcp(shcp[1]), .stcp(stcp[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s[dut%0d] actual=%0h required=%0h", nm, idx, act, req);
    end
  endtask

  function automatic int div_of(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  // Frame-level reference: a frame occupies 33*DIV busy cycles plus one
  // idle decision cycle; a new word is sent whenever the driver is free.
  longint      cyc;
  longint      free_at[2];
  bit          first_m[2];
  logic [15:0] last_m[2];

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        for (int i = 0; i < 2; i++) begin
          first_m[i] = 1'b1;
          free_at[i] = 0;
        end
        exp_a.delete();
        exp_b.delete();
      end else if (clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
          if (cyc >= free_at[i] && (first_m[i] || {sel, seg} != last_m[i])) begin
            first_m[i] = 1'b0;
            last_m[i]  = {sel, seg};
            free_at[i] = cyc + 33 * div_of(i) + 1;
            if (i == 0) exp_a.push_back({sel, seg});
            else        exp_b.push_back({sel, seg});
          end
        end
      end
    end
  end

  // Pin monitor: two chained 595s shift ds on shcp rise, latch on stcp rise.
  logic [15:0] chain[2];
  logic [15:0] latched[2];
  logic        pshcp[2], pstcp[2], pbusy[2], pds[2];
  int          rises[2], blen[2];
  logic [15:0] e;

  initial begin
    for (int i = 0; i < 2; i++) begin
      chain[i] = 16'd0; latched[i] = 16'd0;
      pshcp[i] = 0; pstcp[i] = 0; pbusy[i] = 0; pds[i] = 0;
      rises[i] = 0; blen[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (!rstn) begin
          rises[i] = 0; blen[i] = 0;
          pshcp[i] = 0; pstcp[i] = 0; pbusy[i] = 0; pds[i] = 0;
        end else begin
          if (shcp[i] && !pshcp[i]) begin
            chk("ds_stable_at_shcp_rise", i, 32'(ds[i]), 32'(pds[i]));
            chain[i] = {chain[i][14:0], ds[i]};
            rises[i]++;
          end
          if (stcp[i] && !pstcp[i]) begin
            chk("shcp_low_at_stcp_rise", i, 32'(shcp[i]), 32'd0);
            chk("shcp_rises_per_frame", i, 32'(rises[i]), 32'd16);
            rises[i] = 0;
            latched[i] = chain[i];
            if ((i == 0 ? exp_a.size() : exp_b.size()) == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_frame[dut%0d] actual=%0h required=none", i, chain[i]);
            end else begin
              e = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
              chk("latched_word", i, 32'(chain[i]), 32'(e));
            end
          end
          if (busy[i]) begin
            blen[i]++;
          end else begin
            if (pbusy[i]) begin
              chk("busy_length", i, 32'(blen[i]), 32'(33 * div_of(i)));
              blen[i] = 0;
            end
            chk("idle_pins_low", i, {29'd0, ds[i], shcp[i], stcp[i]}, 32'd0);
          end
          pshcp[i] = shcp[i]; pstcp[i] = stcp[i]; pbusy[i] = busy[i]; pds[i] = ds[i];
        end
      end
    end
  end

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    repeat (2) @(negedge clk);
    while ((busy != 2'b00) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", 0, {30'd0, busy}, 32'd0);
  endtask

  task automatic wait_busy_a(input int budget);
    int n;
    n = 0;
    while (!busy[0] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("busy_rise_within_budget", 0, 32'(busy[0]), 32'd1);
  endtask

  initial begin
    seg = 8'hC0;
    sel = 8'h01;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++)
      chk("reset_outputs", i, {28'd0, ds[i], shcp[i], stcp[i], busy[i]}, 32'd0);

    // First frame after reset, even though nothing "changed".
    rstn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("busy_after_release", i, 32'(busy[i]), 32'd1);
      chk("first_ds_bit", i, 32'(ds[i]), 32'd0);
    end
    wait_idle(1000);
    chk("first_frame_word", 0, 32'(latched[0]), 32'h01C0);
    chk("first_frame_word", 1, 32'(latched[1]), 32'h01C0);

    // Constant inputs: the monitor flags any edge or non-idle pin.
    repeat (1000) @(negedge clk);

    // Changes during a frame: only the newest value follows it.
    sel = 8'h02;
    wait_busy_a(50);
    repeat (20) @(negedge clk);
    seg = 8'hF9;
    repeat (20) @(negedge clk);
    seg = 8'hA4;
    wait_idle(2000);
    repeat (5) @(negedge clk);
    chk("newest_word_sent", 0, 32'(latched[0]), 32'h02A4);
    chk("newest_word_sent", 1, 32'(latched[1]), 32'h02A4);

    // Reset part-way through bit 7 of a frame.
    sel = 8'h04;
    wait_busy_a(50);
    repeat (7 * 2 * DIV_A + 1) @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++)
      chk("async_reset_outputs", i, {28'd0, ds[i], shcp[i], stcp[i], busy[i]}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    wait_idle(2000);
    chk("resent_after_reset", 0, 32'(latched[0]), 32'h04A4);
    chk("resent_after_reset", 1, 32'(latched[1]), 32'h04A4);

    // Random traffic, some repeats of the current word.
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 3) != 0) begin
        seg = 8'($urandom);
        sel = 8'($urandom);
      end
      repeat ($urandom_range(1, 200)) @(negedge clk);
    end
    wait_idle(2000);
    repeat (200) @(negedge clk);
    chk("pending_frames", 0, 32'(exp_a.size()), 32'd0);
    chk("pending_frames", 1, 32'(exp_b.size()), 32'd0);
    chk("final_word", 0, 32'(latched[0]), 32'({sel, seg}));
    chk("final_word", 1, 32'(latched[1]), 32'({sel, seg}));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
